// File: rtl/cla_iter_adder_seq_pkg.sv
// rtl/cla_iter_adder_seq_pkg.sv - shared types and constants for the iterative CLA adder
// Purpose: FSM state encoding, slice geometry and opcode constants.
// Ports: none (package).
package cla_iter_adder_seq_pkg;

  localparam int SLICE_W      = 4;
  localparam int WORD_NIBBLES = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_iter_adder_seq_if.sv
// rtl/cla_iter_adder_seq_if.sv - request/response bundle for the iterative CLA adder
// Purpose: groups the request handshake, operands and the result handshake/flags.
// Ports: in_valid/in_ready/in_a/in_b/in_sub/in_word (request),
//        out_valid/out_ready/out_result/out_cout/out_ovf/out_zero (response).
// master = requester/consumer side, slave = adder side.
interface cla_iter_adder_seq_if #(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            in_sub;
  logic            in_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_cout;
  logic            out_ovf;
  logic            out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_word, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_word, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/fourbit_cla.sv
// rtl/fourbit_cla.sv - 4-bit carry-lookahead slice
// Purpose: nibble sum with bitwise propagate/generate exported so the caller
//          can form group and MSB carries itself.
// Ports: a, b (nibble operands), cin (carry in), s (sum), p/g (propagate/generate).
module fourbit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:0] p,
  output logic [3:0] g
);

  logic c1, c2, c3;

  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign s  = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_iter_adder_seq.sv
// rtl/cla_iter_adder_seq.sv - multi-cycle adder/subtractor using one 4-bit CLA slice
// Purpose: ADD/SUB/ADDW/SUBW, one nibble per clock LSB first; result and flags
//          held until the consumer accepts them.
// Ports: clk, rst (sync active-high), bus (slave side of cla_iter_adder_seq_if).
module cla_iter_adder_seq
  import cla_iter_adder_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_iter_adder_seq_if.slave  bus
);

  localparam int N     = XLEN / SLICE_W;
  localparam int IDX_W = $clog2(N);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             carry_q, carry_d;
  logic             word_q, word_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [IDX_W+1:0] bit_pos;
  logic [IDX_W-1:0] last_idx;
  logic [3:0]       a_nib, b_nib, slice_s, slice_p, slice_g;
  logic             c3, c4;

  assign bit_pos  = {idx_q, 2'b00};
  assign a_nib    = a_q[bit_pos +: SLICE_W];
  assign b_nib    = b_q[bit_pos +: SLICE_W];
  assign last_idx = word_q ? IDX_W'(WORD_NIBBLES - 1) : IDX_W'(N - 1);

  fourbit_cla u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .s   (slice_s),
    .p   (slice_p),
    .g   (slice_g)
  );

  // c3 is the carry into the nibble MSB; on the last nibble c3^c4 is signed overflow.
  assign c3 = slice_g[2] | slice_p[2] & (slice_g[1] | slice_p[1] & (slice_g[0] | slice_p[0] & carry_q));
  assign c4 = slice_g[3] | slice_p[3] & c3;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    word_d   = word_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction as A + ~B + 1: invert B here, the +1 rides in as carry-in.
          a_d     = bus.in_a;
          b_d     = bus.in_b ^ {XLEN{bus.in_sub == OP_SUB}};
          carry_d = (bus.in_sub == OP_SUB);
          word_d  = bus.in_word;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[bit_pos +: SLICE_W] = slice_s;
        carry_d = c4;
        idx_d   = idx_q + 1'b1;
        if (idx_q == last_idx) begin
          state_d = ST_DONE;
          idx_d   = '0;
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
          // Upper half may still hold an older result; overwrite with the sign.
          if (word_q) result_d[XLEN-1:32] = {(XLEN-32){slice_s[3]}};
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      word_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      word_q   <= word_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE) & ~rst;
  assign bus.out_valid  = (state_q == ST_DONE) & ~rst;
  assign bus.out_result = result_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_zero   = (result_q == '0);

endmodule

// File: tb/tb_cla_iter_adder_seq.sv
// tb/tb_cla_iter_adder_seq.sv - self-checking bench for cla_iter_adder_seq
module tb_cla_iter_adder_seq;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  cla_iter_adder_seq_if #(.XLEN(XLEN)) bif ();

  cla_iter_adder_seq #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain two's-complement arithmetic on the operation width.
  task automatic ref_calc(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic word, output logic [63:0] r, output logic co,
                          output logic ov);
    logic [64:0] aa, bx, t;
    int          msb;
    msb = word ? 31 : 63;
    aa  = word ? {33'd0, a[31:0]} : {1'b0, a};
    bx  = word ? {33'd0, b[31:0]} : {1'b0, b};
    if (sub) begin
      t  = aa - bx;
      co = (aa >= bx);
      ov = (aa[msb] != bx[msb]) && (t[msb] != aa[msb]);
    end else begin
      t  = aa + bx;
      co = t[msb+1];
      ov = (aa[msb] == bx[msb]) && (t[msb] != aa[msb]);
    end
    r = word ? {{32{t[31]}}, t[31:0]} : t[63:0];
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (bif.in_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_req", {63'd0, bif.in_ready}, 64'd1);
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic word);
    wait_ready();
    bif.in_valid = 1'b1;
    bif.in_a     = a;
    bif.in_b     = b;
    bif.in_sub   = sub;
    bif.in_word  = word;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_a     = {$urandom, $urandom};
    bif.in_b     = {$urandom, $urandom};
    bif.in_sub   = 1'($urandom);
    bif.in_word  = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int edges;
    edges = 0;
    while (bif.out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, ".latency"}, 64'(edges), 64'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic [63:0] r, input logic co,
                           input logic ov);
    check({tag, ".result"}, bif.out_result, r);
    check({tag, ".cout"},   {63'd0, bif.out_cout}, {63'd0, co});
    check({tag, ".ovf"},    {63'd0, bif.out_ovf},  {63'd0, ov});
    check({tag, ".zero"},   {63'd0, bif.out_zero}, {63'd0, (r == 64'd0)});
  endtask

  task automatic release_out(input string tag);
    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    check({tag, ".valid_after_accept"}, {63'd0, bif.out_valid}, 64'd0);
    check({tag, ".ready_after_accept"}, {63'd0, bif.in_ready},  64'd1);
  endtask

  task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic word, input logic [63:0] er,
                          input logic eco, input logic eov);
    start_op(a, b, sub, word);
    wait_done(tag, word ? 8 : 16);
    check_out(tag, er, eco, eov);
    release_out(tag);
  endtask

  initial begin
    logic [63:0] ra, rb, er;
    logic        rs, rw, eco, eov;

    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_a      = '0;
    bif.in_b      = '0;
    bif.in_sub    = 1'b0;
    bif.in_word   = 1'b0;
    bif.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready_in_rst", {63'd0, bif.in_ready},  64'd0);
    check("reset.out_valid",       {63'd0, bif.out_valid}, 64'd0);
    rst = 1'b0;
    #1;
    check("reset.in_ready_after", {63'd0, bif.in_ready}, 64'd1);
    check_out("reset", 64'd0, 1'b0, 1'b0);

    directed("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    directed("sub_neg",  64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("sub_eq",   64'd7, 64'd7, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    directed("add_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("sub_ovf",  64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    directed("addw_ovf", 64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 1'b1,
             64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1);
    directed("addw_hi",  64'hDEAD_BEEF_0000_0001, 64'h1234_0000_0000_0001, 1'b0, 1'b1,
             64'h2, 1'b0, 1'b0);

    // Backpressure: result held while the consumer stalls, request pulses ignored.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    ref_calc(ra, rb, 1'b0, 1'b0, er, eco, eov);
    start_op(ra, rb, 1'b0, 1'b0);
    wait_done("bp", 16);
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = 1'b1;
      bif.in_a     = {$urandom, $urandom};
      bif.in_b     = {$urandom, $urandom};
      check("bp.in_ready", {63'd0, bif.in_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      bif.in_valid = 1'b0;
      check("bp.out_valid", {63'd0, bif.out_valid}, 64'd1);
      check_out("bp", er, eco, eov);
    end
    release_out("bp");
    directed("bp_next", 64'd100, 64'd58, 1'b1, 1'b0, 64'd42, 1'b1, 1'b0);

    // Reset on the 7th RUN edge abandons the operation.
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.out_valid", {63'd0, bif.out_valid}, 64'd0);
    check("rst_mid.in_ready",  {63'd0, bif.in_ready},  64'd1);
    check("rst_mid.result",    bif.out_result, 64'd0);
    directed("rst_mid_next", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      rs = 1'($urandom);
      rw = 1'($urandom);
      ref_calc(ra, rb, rs, rw, er, eco, eov);
      start_op(ra, rb, rs, rw);
      wait_done("rand", rw ? 8 : 16);
      check_out("rand", er, eco, eov);
      release_out("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
